// File: rtl/thang_may.sv
// Elevator floor-position controller: steps the floor index one floor at a time
// between the programmable bounds min and max, with clamping and a fault hold.
module thang_may #(
    parameter int WIDTH       = 8,
    parameter int STEP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             mode,
    input  logic [WIDTH-1:0] min,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] q
);

    localparam int            CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        UP,
        DOWN,
        AT_TOP,
        AT_BOTTOM,
        FAULT
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [CW-1:0]    w_cnt_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_q     <= w_q_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_q_next     = r_q;
        w_cnt_next   = '0;
        w_cnt_eff    = '0;
        if (min > max) begin
            w_state_next = FAULT;
        end else if (!sel) begin
            w_state_next = IDLE;
        end else if (mode) begin
            if (r_q < min) begin
                w_q_next     = min;
                w_state_next = UP;
            end else if (r_q < max) begin
                w_state_next = UP;
                // A count carried over from a downward move is discarded.
                w_cnt_eff = (r_state == UP) ? r_cnt : '0;
                if (w_cnt_eff == LAST)
                    w_q_next = r_q + 1'b1;
                else
                    w_cnt_next = w_cnt_eff + 1'b1;
            end else begin
                w_q_next     = max;
                w_state_next = AT_TOP;
            end
        end else begin
            if (r_q > max) begin
                w_q_next     = max;
                w_state_next = DOWN;
            end else if (r_q > min) begin
                w_state_next = DOWN;
                w_cnt_eff = (r_state == DOWN) ? r_cnt : '0;
                if (w_cnt_eff == LAST)
                    w_q_next = r_q - 1'b1;
                else
                    w_cnt_next = w_cnt_eff + 1'b1;
            end else begin
                w_q_next     = min;
                w_state_next = AT_BOTTOM;
            end
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_thang_may.sv
// Bench for thang_may: directed plan with literal expectations plus random traffic
// compared every cycle against a floor-stepping reference model (step 1 and step 3).
module tb_thang_may;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       mode;
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] q1;
    logic [7:0] q3;

    int n_cmp = 0;
    int n_err = 0;

    thang_may #(.WIDTH(8), .STEP_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .sel(sel), .mode(mode), .min(mn), .max(mx), .q(q1)
    );
    thang_may #(.WIDTH(8), .STEP_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .sel(sel), .mode(mode), .min(mn), .max(mx), .q(q3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: floor, enabled cycles spent toward the next floor, and the
    // direction those cycles were spent in (0 none, 1 up, 2 down).
    int   steps_of [2] = '{1, 3};
    int   m_q   [2];
    int   m_cnt [2];
    int   m_dir [2];

    task automatic model_step(input int k);
        int f;
        int lo;
        int hi;
        int c;
        f  = m_q[k];
        lo = int'(mn);
        hi = int'(mx);
        if (lo > hi || !sel) begin
            m_cnt[k] = 0;
            m_dir[k] = 0;
        end else begin
            int d;
            d = mode ? 1 : 2;
            if (mode && f < lo) begin
                f = lo; m_cnt[k] = 0; m_dir[k] = 0;
            end else if (!mode && f > hi) begin
                f = hi; m_cnt[k] = 0; m_dir[k] = 0;
            end else if ((mode && f < hi) || (!mode && f > lo)) begin
                c = (m_dir[k] == d) ? m_cnt[k] : 0;
                c = c + 1;
                if (c == steps_of[k]) begin
                    f = mode ? f + 1 : f - 1;
                    c = 0;
                end
                m_cnt[k] = c;
                m_dir[k] = d;
            end else begin
                f = mode ? hi : lo;
                m_cnt[k] = 0;
                m_dir[k] = 0;
            end
        end
        m_q[k] = f;
    endtask

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_q[k] = 0; m_cnt[k] = 0; m_dir[k] = 0;
            end else begin
                model_step(k);
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] act, input int exp);
        n_cmp++;
        if (int'(act) != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, both DUTs are held to the model, 5 ns after the active edge.
    always @(posedge clk) begin
        #5;
        check("dut1_vs_model", q1, m_q[0]);
        check("dut3_vs_model", q3, m_q[1]);
    end

    task automatic edge_check(input string nm, input int which, input int exp);
        @(posedge clk);
        #5;
        check(nm, (which == 1) ? q1 : q3, exp);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0; mode = 1'b1; mn = 8'd0; mx = 8'd7;
        #100;
        check("reset_q1", q1, 0);
        check("reset_q3", q3, 0);
        @(negedge clk);
        rst = 1'b1;

        // Climb to 5, then pulse reset between edges.
        @(negedge clk); sel = 1'b1; mode = 1'b1;
        for (int i = 1; i <= 5; i++) edge_check("climb_to_5", 1, i);
        @(negedge clk); sel = 1'b0; rst = 1'b0;
        #1 check("async_reset", q1, 0);
        @(negedge clk); rst = 1'b1;
        $display("phase reset done");

        // Up to the top and hold, no wrap.
        sel = 1'b1; mode = 1'b1;
        for (int i = 1; i <= 10; i++) edge_check("up_0_7", 1, (i < 7) ? i : 7);
        @(negedge clk); mode = 1'b0;
        for (int i = 1; i <= 10; i++) edge_check("down_7_0", 1, (7 - i > 0) ? 7 - i : 0);
        $display("phase full range done");

        // Narrow window: clamp to min, climb, hold, reverse.
        @(negedge clk); mn = 8'd2; mx = 8'd5; mode = 1'b1;
        edge_check("clamp_min", 1, 2);
        edge_check("win_up", 1, 3);
        edge_check("win_up", 1, 4);
        edge_check("win_up", 1, 5);
        edge_check("win_top_hold", 1, 5);
        @(negedge clk); mode = 1'b0;
        edge_check("win_down", 1, 4);
        edge_check("win_down", 1, 3);
        edge_check("win_down", 1, 2);
        edge_check("win_bot_hold", 1, 2);
        $display("phase window done");

        // Hold with sel=0, then fault, then recovery.
        @(negedge clk); mode = 1'b1;
        edge_check("climb_to_3", 1, 3);
        @(negedge clk); sel = 1'b0;
        for (int i = 0; i < 5; i++) edge_check("sel0_hold", 1, 3);
        @(negedge clk); sel = 1'b1; mn = 8'd6; mx = 8'd4;
        for (int i = 0; i < 3; i++) edge_check("fault_hold", 1, 3);
        @(negedge clk); mx = 8'd7;
        edge_check("fault_exit_clamp", 1, 6);
        edge_check("resume", 1, 7);
        $display("phase fault done");

        // Three-cycle steps and count restart on direction change.
        @(negedge clk); rst = 1'b0; mn = 8'd0; mx = 8'd7;
        @(negedge clk); rst = 1'b1; sel = 1'b1; mode = 1'b1;
        edge_check("slow_up", 3, 0);
        edge_check("slow_up", 3, 0);
        edge_check("slow_up", 3, 1);
        edge_check("slow_up", 3, 1);
        edge_check("slow_up", 3, 1);
        edge_check("slow_up", 3, 2);
        edge_check("slow_up", 3, 2);
        edge_check("slow_up", 3, 2);
        @(negedge clk); mode = 1'b0;
        edge_check("toggle_restart", 3, 2);
        edge_check("toggle_restart", 3, 2);
        edge_check("slow_down", 3, 1);
        $display("phase step3 done");

        // Random traffic, checked by the per-cycle compare process.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            sel = ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 99) < 10) mode = ~mode;
            if ($urandom_range(0, 99) < 6) begin
                mn = 8'($urandom_range(0, 12));
                mx = 8'($urandom_range(0, 15));
            end
        end
        @(negedge clk); rst = 1'b1; sel = 1'b0;
        @(posedge clk); #6;
        $display("phase random done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
